// File: rtl/spart_pkg.sv
// Shared definitions for the SPART transmit-side byte arbiter.
package spart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: search begins at ptr and wraps; emits one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [IDX_W:0] pos;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(NUM_REQ)) pos = pos - (IDX_W + 1)'(NUM_REQ);
      if (req[pos[IDX_W-1:0]]) begin
        grant                 = '0;
        grant[pos[IDX_W-1:0]] = 1'b1;
        idx                   = pos[IDX_W-1:0];
        valid                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spart_tx_arbiter.sv
// Multiplexes NUM_REQ byte requesters onto one SPART transmitter, paced by tbr.
// Define SPART_TX_ARB_PKT_LOCK_EN to hold the grant on one requester until its packet's last byte.
module spart_tx_arbiter
  import spart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         ack,
  input  logic                       tbr,
  output logic                       trans_load,
  output logic [7:0]                 trans_buff,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  tx_state_e          state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [7:0]         buff_q, buff_d;
  logic               load_q, load_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic [IDX_W-1:0]   rr_next;

`ifdef SPART_TX_ARB_PKT_LOCK_EN
  logic               lock_q, lock_d;
  logic [NUM_REQ-1:0] own_mask;

  always_comb begin
    own_mask          = '0;
    own_mask[owner_q] = 1'b1;
  end

  assign arb_req = lock_q ? (req & own_mask) : req;
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign arb_req     = req;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (arb_req),
    .ptr   (rr_q),
    .grant (gnt_onehot),
    .idx   (gnt_idx),
    .valid (gnt_vld)
  );

  assign rr_next = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    buff_d  = buff_q;
    load_d  = 1'b0;
    ack_d   = '0;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef SPART_TX_ARB_PKT_LOCK_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (tbr && gnt_vld) begin
          buff_d  = req_data[8*int'(gnt_idx) +: 8];
          owner_d = gnt_idx;
          load_d  = 1'b1;
          ack_d   = gnt_onehot;
          state_d = ST_LOAD;
`ifdef SPART_TX_ARB_PKT_LOCK_EN
          lock_d  = ~req_last[gnt_idx];
          if (req_last[gnt_idx]) rr_d = rr_next;
`else
          rr_d    = rr_next;
`endif
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // Transmitter never took the byte: flag it and give up on this load.
        if (!tbr) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
`ifdef SPART_TX_ARB_PKT_LOCK_EN
          lock_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (tbr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      buff_q  <= '0;
      load_q  <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      buff_q  <= buff_d;
      load_q  <= load_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SPART_TX_ARB_PKT_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_q <= 1'b0;
    else     lock_q <= lock_d;
  end
`endif

  assign trans_load = load_q;
  assign ack        = ack_q;
  assign trans_buff = buff_q;
  assign owner      = owner_q;
  assign busy       = (state_q != ST_IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_spart_tx_arbiter.sv
// Scoreboard bench for spart_tx_arbiter: requesters, transmitter model and reference order model.
module tb_spart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int MAXB = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   ack;
  logic           tbr;
  logic           trans_load;
  logic [7:0]     trans_buff;
  logic [1:0]     owner;
  logic           busy;
  logic           err;

  logic tx_auto;
  logic tbr_man;
  logic tbr_model = 1'b1;
  int   tx_phase = 0;
  int   tx_cnt = 0;

  assign tbr = tx_auto ? tbr_model : tbr_man;

  spart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .ack        (ack),
    .tbr        (tbr),
    .trans_load (trans_load),
    .trans_buff (trans_buff),
    .owner      (owner),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-requester byte lists; ptr is owned by the requester process.
  logic [7:0] mem [N][MAXB];
  logic       lst [N][MAXB];
  int         cnt [N];
  int         ptr [N];
  int         scn_id = 0;
  int         last_scn = 0;

  int         exp_w [$];
  logic [7:0] exp_b [$];

  task automatic push_exp(input int w, input logic [7:0] b);
    exp_w.push_back(w);
    exp_b.push_back(b);
  endtask

  // Requesters: hold req with the current byte until acked, then present the next.
  always @(negedge clk) begin
    if (scn_id != last_scn) begin
      for (int i = 0; i < N; i++) ptr[i] = 0;
      last_scn = scn_id;
    end else begin
      for (int i = 0; i < N; i++) if (ack[i]) ptr[i]++;
    end
    for (int i = 0; i < N; i++) begin
      if (ptr[i] < cnt[i]) begin
        req[i]             = 1'b1;
        req_data[8*i +: 8] = mem[i][ptr[i]];
        req_last[i]        = lst[i][ptr[i]];
      end else begin
        req[i]             = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  end

  // Transmitter: after a load, drop tbr briefly then raise it when the frame is done.
  always @(negedge clk) begin
    if (!tx_auto || rst) begin
      tx_phase  = 0;
      tbr_model = 1'b1;
    end else if (trans_load) begin
      chk("load_while_tx_busy", tx_phase, 0);
      tx_phase = 1;
      tx_cnt   = $urandom_range(0, 2);
    end else if (tx_phase == 1) begin
      if (tx_cnt == 0) begin
        tbr_model = 1'b0;
        tx_phase  = 2;
        tx_cnt    = $urandom_range(1, 5);
      end else tx_cnt--;
    end else if (tx_phase == 2) begin
      if (tx_cnt == 0) begin
        tbr_model = 1'b1;
        tx_phase  = 0;
      end else tx_cnt--;
    end
  end

  // Monitor: every load is matched against the next expected (requester, byte).
  always @(negedge clk) begin
    if (trans_load) begin
      chk("load_has_expectation", exp_w.size() > 0, 1);
      if (exp_w.size() > 0) begin
        int         w;
        logic [7:0] b;
        logic [N-1:0] oh;
        w  = exp_w.pop_front();
        b  = exp_b.pop_front();
        oh = '0;
        oh[w] = 1'b1;
        chk("grant_owner", owner, w);
        chk("grant_byte", trans_buff, b);
        chk("grant_ack", ack, oh);
      end
    end else if (ack != '0) begin
      chk("ack_without_load", ack, 0);
    end
  end

  // Reference order: round-robin over requesters with remaining bytes.
  task automatic build_expected();
    int p [N];
    int rr = 0;
    int own = 0;
    bit locked = 1'b0;
    int left = 0;
    for (int i = 0; i < N; i++) begin
      p[i] = 0;
      left += cnt[i];
    end
    while (left > 0) begin
      int  w = -1;
      bit  last;
      if (locked) w = own;
      else begin
        for (int k = 0; k < N; k++) begin
          int i = (rr + k) % N;
          if (w < 0 && p[i] < cnt[i]) w = i;
        end
      end
      push_exp(w, mem[w][p[w]]);
      last = lst[w][p[w]];
      p[w]++;
      left--;
`ifdef SPART_TX_ARB_PKT_LOCK_EN
      locked = !last;
      own    = w;
      if (last) rr = (w + 1) % N;
`else
      if (last || !last) rr = (w + 1) % N;
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) cnt[i] = 0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int  n = 0;
    bit  pend = 1'b1;
    while (pend && n < budget) begin
      @(negedge clk);
      n++;
      pend = (exp_w.size() != 0) || busy || (tx_phase != 0);
      for (int i = 0; i < N; i++) if (ptr[i] < cnt[i]) pend = 1'b1;
    end
    chk(nm, n < budget, 1);
  endtask

  task automatic wait_load(input string nm);
    int n = 0;
    while (!trans_load && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, trans_load, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    tx_auto = 1'b1;
    tbr_man = 1'b1;
    clear_reqs();
    repeat (3) @(negedge clk);
    chk("rst_trans_load", trans_load, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_owner", owner, 0);
    chk("rst_trans_buff", trans_buff, 0);
    rst = 1'b0;

    // Single request: load and ack one cycle after the request is seen.
    @(posedge clk); #1;
    mem[2][0] = 8'hA5; lst[2][0] = 1'b1; cnt[2] = 1;
    push_exp(2, 8'hA5);
    scn_id++;
    @(negedge clk);
    @(negedge clk);
    chk("single_load", trans_load, 1);
    chk("single_ack", ack, 4'b0100);
    chk("single_buff", trans_buff, 8'hA5);
    chk("single_owner", owner, 2);
    chk("single_busy", busy, 1);
    wait_idle("single_done", 200);
    chk("buff_hold", trans_buff, 8'hA5);
    chk("owner_hold", owner, 2);

    // All requesting: strict rotation.
    do_reset();
    clear_reqs();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) begin
        mem[i][r] = 8'(16 * i + r + 1);
        lst[i][r] = 1'b1;
        cnt[i]    = 2;
      end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_exp(i, 8'(16 * i + r + 1));
    scn_id++;
    wait_idle("rotation_done", 1000);

    // Packet: req0 sends three bytes (last on the third), req1 always requesting.
    do_reset();
    clear_reqs();
    mem[0][0] = 8'h10; lst[0][0] = 1'b0;
    mem[0][1] = 8'h11; lst[0][1] = 1'b0;
    mem[0][2] = 8'h12; lst[0][2] = 1'b1;
    mem[1][0] = 8'h20; lst[1][0] = 1'b1;
    mem[1][1] = 8'h21; lst[1][1] = 1'b1;
    cnt[0] = 3; cnt[1] = 2;
`ifdef SPART_TX_ARB_PKT_LOCK_EN
    push_exp(0, 8'h10); push_exp(0, 8'h11); push_exp(0, 8'h12);
    push_exp(1, 8'h20); push_exp(1, 8'h21);
`else
    push_exp(0, 8'h10); push_exp(1, 8'h20); push_exp(0, 8'h11);
    push_exp(1, 8'h21); push_exp(0, 8'h12);
`endif
    scn_id++;
    wait_idle("packet_done", 1000);

    // Randomized traffic against the reference order.
    for (int it = 0; it < 4; it++) begin
      do_reset();
      clear_reqs();
      for (int i = 0; i < N; i++) begin
        cnt[i] = $urandom_range(0, 6);
        for (int b = 0; b < MAXB; b++) begin
          mem[i][b] = 8'($urandom);
          lst[i][b] = 1'($urandom_range(0, 1));
        end
        if (cnt[i] > 0) lst[i][cnt[i] - 1] = 1'b1;
      end
      build_expected();
      scn_id++;
      wait_idle("random_done", 5000);
    end

    // Timeout: tbr never drops after the load.
    do_reset();
    clear_reqs();
    tx_auto = 1'b0;
    tbr_man = 1'b1;
    mem[1][0] = 8'h5A; lst[1][0] = 1'b1; cnt[1] = 1;
    push_exp(1, 8'h5A);
    scn_id++;
    wait_load("timeout_load");
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      if (k == TO) begin
        chk("timeout_err_before", err, 0);
        chk("timeout_busy_before", busy, 1);
      end
      if (k == TO + 1) begin
        chk("timeout_err_set", err, 1);
        chk("timeout_idle", busy, 0);
      end
    end
    tx_auto = 1'b1;
    mem[3][0] = 8'h77; lst[3][0] = 1'b1; cnt[3] = 1;
    push_exp(3, 8'h77);
    wait_idle("after_timeout_done", 500);
    chk("err_sticky", err, 1);
    do_reset();
    chk("err_cleared_by_rst", err, 0);

    // Reset while waiting for the transmitter to finish.
    clear_reqs();
    tx_auto = 1'b0;
    tbr_man = 1'b1;
    mem[2][0] = 8'hB2; lst[2][0] = 1'b1; cnt[2] = 1;
    push_exp(2, 8'hB2);
    scn_id++;
    wait_load("midrst_load");
    tbr_man = 1'b0;
    @(negedge clk);
    mem[0][0] = 8'hC0; lst[0][0] = 1'b1;
    mem[3][0] = 8'hC3; lst[3][0] = 1'b1;
    cnt[0] = 1; cnt[3] = 1;
    @(negedge clk);
    chk("midrst_in_wait", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_load", trans_load, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err, 0);
    chk("midrst_owner", owner, 0);
    chk("midrst_buff", trans_buff, 0);
    push_exp(0, 8'hC0);
    push_exp(3, 8'hC3);
    tx_auto = 1'b1;
    rst = 1'b0;
    wait_idle("midrst_done", 500);

    chk("scoreboard_drained", exp_w.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
